// File: rtl/sliding_window_floating_point.sv
// Raster-order window builder. It uses line buffers for the previous rows and a column shift
// register, and emits one HxW neighbourhood per accepted pixel once enough rows have been seen.
module sliding_window_floating_point #(
  parameter int EXP_WIDTH     = 8,
  parameter int FRAC_WIDTH    = 23,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = $clog2(WINDOW_HEIGHT) + 1;
  localparam logic [RW-1:0] RS_MAX = RW'(WINDOW_HEIGHT - 1);
  localparam logic [15:0] IW16   = 16'(IMAGE_WIDTH);
  localparam logic [15:0] IH16   = 16'(IMAGE_HEIGHT);
  localparam logic [15:0] CLAST  = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] W_M1   = 16'(WINDOW_WIDTH - 1);
  localparam logic [15:0] H_M1   = 16'(WINDOW_HEIGHT - 1);
  localparam logic [15:0] W_CTR  = 16'(WINDOW_WIDTH / 2);
  localparam logic [15:0] H_CTR  = 16'(WINDOW_HEIGHT / 2);

  logic                    accept;
  logic [AW-1:0]           addr;
  logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0] colv;

  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_q, win_d;
  logic [RW-1:0] rows_seen_q, rows_seen_d;
  logic [15:0]   col_q, col_d, row_q, row_d;
  logic          valid_q, valid_d;

  // Reset blocks the buffer write too, so a pixel arriving with reset leaves no trace.
  assign accept = valid_i && !rst_i && (col_i < IW16) && (row_i < IH16);
  assign addr   = col_i[AW-1:0];
  assign colv[WINDOW_HEIGHT-1] = data_i;

  // LB[k] holds row (current-1-k); writing colv[H-1-k] shifts each column down one buffer.
  if (WINDOW_HEIGHT > 1) begin : g_lb
    for (genvar gi = 0; gi < WINDOW_HEIGHT - 1; gi++) begin : g_line
      logic [FP_WIDTH_REG-1:0] lb_mem [IMAGE_WIDTH];

      assign colv[WINDOW_HEIGHT-2-gi] = lb_mem[addr];

      always_ff @(posedge clk_i) begin
        if (accept) begin
          lb_mem[addr] <= colv[WINDOW_HEIGHT-1-gi];
        end
      end
    end
  end

  always_comb begin
    win_d       = win_q;
    rows_seen_d = rows_seen_q;
    col_d       = col_q;
    row_d       = row_q;
    valid_d     = 1'b0;
    if (accept) begin
      if (col_i == 16'd0 && row_i == 16'd0) begin
        rows_seen_d = '0;
      end
      if (col_i == CLAST && rows_seen_d < RS_MAX) begin
        rows_seen_d = rows_seen_d + 1'b1;
      end
      valid_d = (row_i >= H_M1) && (col_i >= W_M1) && (rows_seen_q >= RS_MAX);
      if (valid_d) begin
        col_d = col_i - W_M1 + W_CTR;
        row_d = row_i - H_M1 + H_CTR;
      end
      for (int r = 0; r < WINDOW_HEIGHT; r++) begin
        for (int c = 0; c < WINDOW_WIDTH - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WINDOW_WIDTH-1] = colv[r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q       <= '0;
      rows_seen_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      win_q       <= win_d;
      rows_seen_q <= rows_seen_d;
      col_q       <= col_d;
      row_q       <= row_d;
      valid_q     <= valid_d;
    end
  end

  assign window_o = win_q;
  assign col_o    = col_q;
  assign row_o    = row_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_sliding_window_floating_point.sv
// Directed/random bench for the window builder. It runs a 3x3 and a 5-row x 4-col window on an 8x6 image
// and compares against a frame-array reference model.
module tb_sliding_window_floating_point;

  localparam int FPW = 32;
  localparam int IW = 8, IH = 6;
  localparam int WA = 3, HA = 3;
  localparam int WB = 4, HB = 5;
  localparam int VW = 640;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [FPW-1:0] data_a, data_b;
  logic [15:0]    col_a, row_a, col_b, row_b;
  logic           val_a, val_b;
  logic [HA-1:0][WA-1:0][FPW-1:0] win_a;
  logic [HB-1:0][WB-1:0][FPW-1:0] win_b;
  logic [15:0]    colo_a, rowo_a, colo_b, rowo_b;
  logic           vo_a, vo_b;

  sliding_window_floating_point #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .WINDOW_WIDTH(WA), .WINDOW_HEIGHT(HA),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_a), .col_i(col_a), .row_i(row_a),
    .valid_i(val_a), .window_o(win_a), .col_o(colo_a), .row_o(rowo_a), .valid_o(vo_a)
  );

  sliding_window_floating_point #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .WINDOW_WIDTH(WB), .WINDOW_HEIGHT(HB),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_b), .col_i(col_b), .row_i(row_b),
    .valid_i(val_b), .window_o(win_b), .col_o(colo_b), .row_o(rowo_b), .valid_o(vo_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [FPW-1:0] img [2][IH][IW];
  bit             started [2];
  int             pulses, nan_hits, snap_n;
  int             first_col, first_row;
  logic [VW-1:0]  last_win, snap_win;

  function automatic logic [31:0] fbits(int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 24; i++) if (((n >> i) & 1) != 0) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the selected DUT, then check its registered response against the model.
  task automatic step(input int sel, input logic [31:0] d, input int c, input int r,
                      input bit v, input bit rs);
    bit acc, ev;
    int W, H;
    logic [VW-1:0] ew, ow;
    logic [15:0] oc, orow;
    logic ov;
    W = sel ? WB : WA;
    H = sel ? HB : HA;
    rst    = rs;
    data_a = d; col_a = 16'(c); row_a = 16'(r); val_a = v && (sel == 0);
    data_b = d; col_b = 16'(c); row_b = 16'(r); val_b = v && (sel == 1);
    @(posedge clk);
    #1;
    acc = v && !rs && c >= 0 && c < IW && r >= 0 && r < IH;
    if (rs) begin
      started[0] = 1'b0;
      started[1] = 1'b0;
    end
    ev = 1'b0;
    ew = '0;
    if (acc) begin
      if (c == 0 && r == 0) started[sel] = 1'b1;
      img[sel][r][c] = d;
      ev = started[sel] && r >= H - 1 && c >= W - 1;
      if (ev)
        for (int rr = 0; rr < H; rr++)
          for (int cc = 0; cc < W; cc++)
            ew[(rr*W+cc)*32 +: 32] = img[sel][r-H+1+rr][c-W+1+cc];
    end
    ow = '0;
    if (sel == 0) begin
      ov = vo_a; oc = colo_a; orow = rowo_a; ow[HA*WA*FPW-1:0] = win_a;
    end else begin
      ov = vo_b; oc = colo_b; orow = rowo_b; ow[HB*WB*FPW-1:0] = win_b;
    end
    $display("step s%0d rst=%0d v=%0d in(r=%0d,c=%0d) -> valid_o=%0d exp=%0d out(r=%0d,c=%0d)",
             sel, rs, v, r, c, ov, ev, orow, oc);
    check($sformatf("valid_o s%0d r%0d c%0d", sel, r, c), VW'(ov), VW'(ev));
    if (rs) begin
      check($sformatf("rst col_o s%0d", sel), VW'(oc), '0);
      check($sformatf("rst row_o s%0d", sel), VW'(orow), '0);
      check($sformatf("rst window_o s%0d", sel), ow, '0);
    end
    if (ev) begin
      pulses++;
      check($sformatf("col_o s%0d r%0d c%0d", sel, r, c), VW'(oc), VW'(c - (W - 1) + W / 2));
      check($sformatf("row_o s%0d r%0d c%0d", sel, r, c), VW'(orow), VW'(r - (H - 1) + H / 2));
      check($sformatf("window_o s%0d r%0d c%0d", sel, r, c), ow, ew);
      if (pulses == 1) begin
        first_col = int'(oc);
        first_row = int'(orow);
      end
      if (pulses == snap_n) snap_win = ow;
      last_win = ow;
      for (int k = 0; k < W * H; k++) begin
        if (ow[k*32 +: 32] == 32'h7FC00001) begin
          nan_hits++;
          break;
        end
      end
    end
  endtask

  task automatic frame(input int sel, input int base, input bit gaps, input bit inj,
                       input bit nan, input int stop_r, input int stop_c);
    logic [31:0] px;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps) while ($urandom_range(1) == 0) step(sel, $urandom, c, r, 1'b0, 1'b0);
        if (inj && r == 2 && c == 4) step(sel, 32'hDEADBEEF, 8, r, 1'b1, 1'b0);
        px = (nan && r == 2 && c == 3) ? 32'h7FC00001 : fbits(base + r * 8 + c);
        step(sel, px, c, r, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_a = '0; col_a = '0; row_a = '0; val_a = 1'b0;
    data_b = '0; col_b = '0; row_b = '0; val_b = 1'b0;
    snap_n = 0; nan_hits = 0; pulses = 0; first_col = -1; first_row = -1;
    last_win = '0; snap_win = '0;

    // Reset with valid_i high: reset must dominate.
    step(0, fbits(5), 0, 0, 1'b1, 1'b1);
    step(1, fbits(5), 0, 0, 1'b1, 1'b1);
    check("rst valid_o b", VW'(vo_b), '0);
    check("rst window_o b", VW'(win_b), '0);

    // Continuous frame, 3x3.
    pulses = 0;
    frame(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("frame1 pulses", VW'(pulses), VW'(24));
    check("frame1 first col_o", VW'(first_col), VW'(1));
    check("frame1 first row_o", VW'(first_row), VW'(1));
    check("frame1 last w22", VW'(last_win[(2*WA+2)*32 +: 32]), VW'(32'h423C0000));

    // Same frame with random gaps.
    pulses = 0;
    frame(0, 0, 1'b1, 1'b0, 1'b0, -1, -1);
    check("gap frame pulses", VW'(pulses), VW'(24));

    // Back-to-back frames; second frame offset by 100.
    pulses = 0;
    snap_n = 25;
    frame(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(0, 100, 1'b0, 1'b0, 1'b0, -1, -1);
    snap_n = 0;
    check("b2b pulses", VW'(pulses), VW'(48));
    check("b2b first w00", VW'(snap_win[31:0]), VW'(fbits(100)));
    check("b2b first w22", VW'(snap_win[(2*WA+2)*32 +: 32]), VW'(fbits(118)));

    // Reset during row 3, then restart at (0,0).
    frame(0, 0, 1'b0, 1'b0, 1'b0, 3, 4);
    step(0, fbits(7), 4, 3, 1'b1, 1'b1);
    step(0, fbits(7), 5, 3, 1'b0, 1'b1);
    pulses = 0; first_col = -1; first_row = -1;
    frame(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    check("post-rst pulses", VW'(pulses), VW'(24));
    check("post-rst first col_o", VW'(first_col), VW'(1));
    check("post-rst first row_o", VW'(first_row), VW'(1));

    // Out-of-range column injected mid-row.
    pulses = 0;
    frame(0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
    check("inject pulses", VW'(pulses), VW'(24));

    // 5-row x 4-col window with a NaN payload at row 2, col 3.
    pulses = 0; nan_hits = 0;
    frame(1, 0, 1'b1, 1'b0, 1'b1, -1, -1);
    check("nan frame pulses", VW'(pulses), VW'(10));
    check("nan windows", VW'(nan_hits), VW'(8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sliding_window_floating_point.md
Name: sliding_window_floating_point

Overview:
Upstream neighbour of the floating-point convolution stage. Consumes a raster-order pixel stream of floating-point words and builds a WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood per pixel. Uses WINDOW_HEIGHT-1 line buffers and a column shift register. Drives window, col, row and valid directly into the convolution stage's window_i/col_i/row_i/valid_i; the kernel is supplied separately.

Parameters:
EXP_WIDTH, 8, exponent bits of the float format
FRAC_WIDTH, 23, fraction bits of the float format
WINDOW_WIDTH, 3, window columns (>=1)
WINDOW_HEIGHT, 3, window rows (>=1)
IMAGE_WIDTH, 640, pixels per row (>= WINDOW_WIDTH, <= 65535)
IMAGE_HEIGHT, 480, rows per frame (>= WINDOW_HEIGHT, <= 65535)
FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local word width, not overridden

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
data_i  in  FP_WIDTH_REG  input pixel, opaque float bits
col_i  in  16  column of data_i
row_i  in  16  row of data_i
valid_i  in  1  data_i/col_i/row_i qualifier
window_o  out  FP_WIDTH_REG x [WINDOW_HEIGHT][WINDOW_WIDTH]  neighbourhood; [0][0] top-left, [H-1][W-1] = newest pixel
col_o  out  16  window centre column
row_o  out  16  window centre row
valid_o  out  1  window_o/col_o/row_o qualifier, one-cycle pulse per window

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous, active-high.
- No backpressure. Upstream must deliver strict raster order: within a frame, row-major, col 0..IMAGE_WIDTH-1. Gaps (valid_i low) are allowed anywhere.
- Reset values: valid_o=0, col_o=0, row_o=0, window_o all zero, rows_seen=0. Line buffer RAM contents are not reset.
- Reset dominates any same-cycle valid_i. Reset mid-frame discards the partial frame. No valid_o occurs until a new frame starts at (0,0) and enough rows are seen.
- Line buffers: LB[0..H-2], each IMAGE_WIDTH deep, addressed by col_i.
- Processing when valid_i=1 and col_i<IMAGE_WIDTH and row_i<IMAGE_HEIGHT (accepted pixel):
  - Form a column vector: colv[H-1]=data_i; colv[H-2-k]=LB[k][col_i] for k=0..H-2 (LB[0] is the previous row).
  - Update buffers: LB[0][col_i]<=data_i; LB[k][col_i]<=LB[k-1][col_i] for k>=1.
  - Shift the window left: window_o[r][c]<=window_o[r][c+1]; window_o[r][W-1]<=colv[r].
- Out-of-range pixels (col_i>=IMAGE_WIDTH or row_i>=IMAGE_HEIGHT) are dropped: no buffer write, no shift, valid_o=0.
- When valid_i=0, window_o and the line buffers hold their values.
- rows_seen counter, width clog2(H)+1, saturating at H-1:
  - cleared to 0 on an accepted pixel at (0,0);
  - then incremented on an accepted pixel with col_i==IMAGE_WIDTH-1;
  - frame start and row end in the same cycle (IMAGE_WIDTH==1) result in 1.
- valid_o is registered with the window shift (latency 1 cycle from input):
  - valid_o <= accepted && row_i>=H-1 && col_i>=W-1 && rows_seen>=H-1 (rows_seen value before the update).
- Output coordinates are registered with valid_o and hold otherwise:
  - col_o <= col_i-(W-1)+W/2
  - row_o <= row_i-(H-1)+H/2
  - Integer division; for even windows the centre is the lower-right of the middle four.
- Row wrap: stale previous-row columns in the shift register are never exposed, because valid_o is gated by col_i>=W-1.
- Frame wrap: back-to-back frames need no gap; previous-frame buffer contents are gated by rows_seen.
- Per full frame exactly (IMAGE_WIDTH-W+1)*(IMAGE_HEIGHT-H+1) valid_o pulses occur, in raster order.
- Degenerate case W=H=1: window_o[0][0]=data_i, one pulse per accepted pixel, no line buffers.
- Data bits pass through unmodified: no float arithmetic, NaN/denormal payloads preserved.

Test Plan:
- FP32, 8x6 image, 3x3 window, pixel value float(row*8+col), continuous valid_i. First valid_o comes 1 cycle after input (2,2): col_o=1, row_o=1, window rows {0,1,2},{8,9,10},{16,17,18}. Frame totals 24 pulses; last pulse is col_o=6, row_o=4 with window_o[2][2]=47.0.
- Same frame with random valid_i gaps (~50% duty) -> identical sequence of 24 windows and coordinates; valid_o never asserted in a cycle after valid_i=0.
- Two back-to-back frames, second frame values +100.0 -> second frame's first window is 100..118 with no first-frame data; 48 pulses total.
- Assert rst_i during row 3 of frame 1, then restart at (0,0) -> no valid_o until (2,2) of the new frame; all outputs zero during reset.
- Inject col_i=8 (out of range) with valid_i mid-row -> no valid_o, buffers unchanged, following windows match the golden model.
- 5x4 window on 8x6 image, NaN 0x7FC00001 at (3,2) -> pulses have row_o=2..3 and col_o=2..5; NaN bits appear unaltered in all windows covering (3,2).
